// File: rtl/oct_scan_pkg.sv
// Shared types and constants for the octal digit scanner.
// Imported by oct_tick_gen and oct_scan_mux.
package oct_scan_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    SCAN0 = 2'd1,
    SCAN1 = 2'd2,
    SCAN2 = 2'd3
  } state_t;

  localparam logic [2:0] DIG_ALL_OFF = 3'b111;
  localparam int NUM_DIGITS = 3;

  // Active-low one-hot enable for a digit slot.
  function automatic logic [2:0] slot_en(
    input int unsigned slot
  );
    logic [2:0] oh;
    oh = 3'b001 << slot;
    return ~oh;
  endfunction

endpackage

// File: rtl/oct_tick_gen.sv
// Refresh prescaler: tick is high on the last count of each slot.
// Ports: clk, rst_n (sync, active-low), tick (out).
module oct_tick_gen
  import oct_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  // With REFRESH_DIV=1 the counter stays at 0 and tick is constant.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/oct_scan_mux.sv
// Scans an 8-bit value out as three octal digits, one slot at a time.
// Ports: clk, rst_n, load, value[7:0] in; digit, dig_en, blank, frame_start out.
module oct_scan_mux
  import oct_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_EN    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic [2:0] digit,
  output logic [2:0] dig_en,
  output logic       blank,
  output logic       frame_start
);

  localparam logic BLANK_ON = (BLANK_EN != 0);

  logic       tick;
  state_t     state;
  state_t     state_nx;
  logic [7:0] shadow;
  logic [7:0] active;
  logic [7:0] active_nx;
  logic       pending;
  logic       enter0;
  logic       commit;
  logic [2:0] code_nx;
  logic [2:0] en_nx;
  logic       dark_nx;

  oct_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_comb begin
    state_nx = state;
    if (tick) begin
      case (state)
        OFF:     state_nx = SCAN0;
        SCAN0:   state_nx = SCAN1;
        SCAN1:   state_nx = SCAN2;
        SCAN2:   state_nx = SCAN0;
        default: state_nx = OFF;
      endcase
    end
  end

  assign enter0 = tick && (state_nx == SCAN0);
  assign commit = enter0 && pending;

  // Outputs are registered from the post-edge state and value.
  assign active_nx = commit ? shadow : active;

  always_comb begin
    code_nx = 3'b000;
    en_nx   = DIG_ALL_OFF;
    dark_nx = 1'b1;
    case (state_nx)
      SCAN0: begin
        code_nx = active_nx[2:0];
        en_nx   = slot_en(0);
        dark_nx = 1'b0;
      end
      SCAN1: begin
        code_nx = active_nx[5:3];
        en_nx   = slot_en(1);
        dark_nx = BLANK_ON && (active_nx[7:3] == 5'd0);
      end
      SCAN2: begin
        code_nx = {1'b0, active_nx[7:6]};
        en_nx   = slot_en(2);
        dark_nx = BLANK_ON && (active_nx[7:6] == 2'd0);
      end
      default: begin
        code_nx = 3'b000;
        en_nx   = DIG_ALL_OFF;
        dark_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= OFF;
      shadow      <= 8'd0;
      active      <= 8'd0;
      pending     <= 1'b0;
      digit       <= 3'b000;
      dig_en      <= DIG_ALL_OFF;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      active      <= active_nx;
      frame_start <= enter0;
      // A load on the commit edge re-arms pending for the next frame.
      if (commit) begin
        pending <= 1'b0;
      end
      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end
      if (tick) begin
        digit  <= dark_nx ? 3'b000 : code_nx;
        dig_en <= dark_nx ? DIG_ALL_OFF : en_nx;
        blank  <= dark_nx;
      end
    end
  end

endmodule

// File: doc/oct_scan_mux.md
# oct_scan_mux

Time-multiplexed scanner that holds an 8-bit ALU result and presents it as three octal digits, one at a time, to the octal 7-segment decoder. It sits directly upstream of that decoder. Each cycle it supplies the current 3-bit digit code, the active-low digit enable, a blank flag and a frame marker. New values are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range ≥1; prescaler width is $clog2(REFRESH_DIV) (minimum 1 bit).
- BLANK_EN, 1: 1 enables leading-zero blanking of digits 2 and 1.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- load  in  1  single-cycle strobe that captures value.
- value  in  8  unsigned result to display.
- digit  out  3  current octal digit code; digit[0]→A0, digit[1]→A1, digit[2]→A2 of the decoder.
- dig_en  out  3  active-low one-hot digit enable; bit i is octal digit i (i=0 is least significant).
- blank  out  1  1 means the current slot is dark.
- frame_start  out  1  one-cycle pulse when slot 0 is entered.

## Operation
- Prescaler counts 0..REFRESH_DIV-1, then wraps. tick=1 when count==REFRESH_DIV-1. With REFRESH_DIV=1, tick fires every cycle.
- Registers:
  - shadow[7:0] and pending: loaded by load.
  - active[7:0]: the value being displayed.
- load: shadow<=value and pending<=1. A later load before commit overwrites shadow (last wins).
- FSM states: OFF, SCAN0, SCAN1, SCAN2.
  - OFF→SCAN0 on tick.
  - SCAN0→SCAN1→SCAN2→SCAN0, each on tick.
  - No other transitions.
- Commit on any tick entering SCAN0: if pending, active<=shadow and pending<=0. If load occurs in the same cycle as the commit tick, the new value goes to shadow and stays pending for the next frame; the committed value is the old shadow.
- Digit codes (from active):
  - slot 0: active[2:0]
  - slot 1: active[5:3]
  - slot 2: {1'b0, active[7:6]}
- Blanking (BLANK_EN=1):
  - slot 2 blank iff active[7:6]==0.
  - slot 1 blank iff active[7:3]==0.
  - slot 0 is never blank.
  - BLANK_EN=0: only OFF is blank.
- Outputs while lit: dig_en = ~(1<<slot), blank=0, digit = slot code.
- Outputs while blank or in OFF: dig_en=3'b111, blank=1, digit=3'b000.

## Timing
- Reset values: state=OFF, prescaler=0, active=0, shadow=0, pending=0, digit=0, dig_en=3'b111, blank=1, frame_start=0.
- All outputs are registered. They change on the same edge as the state change the tick causes, and are stable for REFRESH_DIV cycles.
- First tick occurs REFRESH_DIV cycles after reset is released; SCAN0 is visible from that edge.
- frame_start is high for exactly the one cycle after each edge that enters SCAN0.
- Load-to-display latency:
  - from the load edge to the next SCAN0 entry, worst case 3·REFRESH_DIV cycles;
  - a load on a commit edge waits one more full frame.
- rst_n low at any point, including mid-frame or with a load pending: all state returns to reset values on that edge. The pending value is discarded.
- load and rst_n low in the same cycle: reset wins.

## Structure
- Package oct_scan_pkg holds:
  - state enum {OFF, SCAN0, SCAN1, SCAN2};
  - DIG_ALL_OFF = 3'b111;
  - NUM_DIGITS = 3.
- Sub-module oct_tick_gen: parameterized prescaler producing tick; it is reset by the same rst_n.
- The top level contains the FSM, shadow/active registers, digit select and blank logic. It instantiates no decoder; the decoder is connected at the display top.

## Test plan
REFRESH_DIV=4 for all scenarios.
- Reset check: hold rst_n low 3 cycles, then release.
  - Until the first tick: dig_en=111, blank=1, digit=0.
  - At cycle 4: SCAN0 with digit=0, dig_en=110, frame_start=1 for one cycle.
- load value=8'hAB (octal 253).
  - After commit, slots 0/1/2 show digit=3/5/2 with dig_en=110/101/011.
  - Each slot holds for 4 cycles; the pattern repeats.
- load 8'o007, BLANK_EN=1.
  - Slot 0: digit=7.
  - Slots 1 and 2: blank=1, dig_en=111.
  - With BLANK_EN=0, slots 1 and 2 show digit=0 lit.
- load 8'h00: slot 0 lit with digit=0; slots 1 and 2 blank.
- Mid-frame loads: during SCAN1, load 8'h12, then 8'h34 two cycles later.
  - The display keeps the old value through SCAN2.
  - Next frame shows 8'h34 as 4/6/0 (octal 064).
  - 8'h12 never appears.
- Reset mid-frame: assert rst_n low during SCAN2 with a load pending.
  - Next cycle: reset values.
  - After release, 8'h00 is displayed.
